// File: rtl/sram_arbiter.sv
// Two-master SRAM-like port arbiter: instruction fetch and data ports share
// one downstream port. Data wins in IDLE; a granted requester keeps the port
// until its request is accepted or withdrawn. A 1-bit owner FIFO records who
// issued each in-flight transaction so in-order responses route back.
module sram_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  // instruction fetch port
  input  logic                       inst_req,
  input  logic [31:0]                inst_addr,
  output logic                       inst_addr_ok,
  output logic                       inst_data_ok,
  output logic [31:0]                inst_rdata,
  // data port
  input  logic                       data_req,
  input  logic                       data_wr,
  input  logic [1:0]                 data_size,
  input  logic [3:0]                 data_wstrb,
  input  logic [31:0]                data_addr,
  input  logic [31:0]                data_wdata,
  output logic                       data_addr_ok,
  output logic                       data_data_ok,
  output logic [31:0]                data_rdata,
  // shared downstream port
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [3:0]                 mem_wstrb,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(DEPTH):0]     outstanding_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t           state;
  logic [DEPTH-1:0] owner;      // 1 = data, 0 = inst
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  logic full;
  logic gnt_i, gnt_d;
  logic push, pop;
  logic head_is_data;

  assign full = (cnt == FULL_CNT);

  // Grant selection: fresh arbitration in IDLE, sticky grant while holding.
  // Reset and a full FIFO suppress any grant so mem_req stays low.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!reset && !full) begin
      case (state)
        IDLE: begin
          if (data_req)      gnt_d = 1'b1;
          else if (inst_req) gnt_i = 1'b1;
        end
        HOLD_D:  gnt_d = data_req;
        HOLD_I:  gnt_i = inst_req;
        default: ;
      endcase
    end
  end

  assign mem_req   = gnt_i | gnt_d;
  assign mem_wr    = gnt_d & data_wr;
  assign mem_size  = gnt_d ? data_size  : 2'd2;
  assign mem_wstrb = gnt_d ? data_wstrb : 4'd0;
  assign mem_addr  = gnt_d ? data_addr  : inst_addr;
  assign mem_wdata = gnt_d ? data_wdata : 32'd0;

  assign inst_addr_ok = mem_addr_ok & gnt_i;
  assign data_addr_ok = mem_addr_ok & gnt_d;

  assign push = mem_req & mem_addr_ok;
  // A response with nothing in flight (e.g. left over from before reset) is dropped.
  assign pop  = !reset & mem_data_ok & (cnt != '0);

  assign head_is_data = owner[rd_ptr];
  assign inst_data_ok = pop & ~head_is_data;
  assign data_data_ok = pop &  head_is_data;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign outstanding_cnt = cnt;

  // Grant FSM: enter HOLD_x when a grant is not accepted, leave on accept or withdraw.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_d && !mem_addr_ok)      state <= HOLD_D;
          else if (gnt_i && !mem_addr_ok) state <= HOLD_I;
        end
        HOLD_D:  if (!data_req || push) state <= IDLE;
        HOLD_I:  if (!inst_req || push) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Owner FIFO storage: record the requester of each accepted transaction.
  always_ff @(posedge clk) begin
    if (push) owner[wr_ptr] <= gnt_d;
  end

  // Owner FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. Expected responses are queued when the
// matching request is accepted; a negedge monitor pops and checks every
// inst/data response the DUT presents.
module tb_sram_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding_cnt;

  sram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding_cnt(outstanding_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input logic is_data, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after posedge; direct checks run 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Response monitor: every data_ok must match the head of the expectation queue.
  always @(negedge clk) begin
    if (inst_data_ok && data_data_ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_both: inst_data_ok and data_data_ok both high");
    end else if (inst_data_ok || data_data_ok) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: inst_ok=%0b data_ok=%0b with nothing expected",
                 inst_data_ok, data_data_ok);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_owner", {31'd0, data_data_ok}, {31'd0, e.is_data});
        chk("rsp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

    // Reset: requests and handshakes high must produce nothing.
    tick();
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    settle();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("rst_cnt", {29'd0, outstanding_cnt}, 32'd0);
    tick();
    reset = 0; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    settle();
    chk("post_rst_cnt", {29'd0, outstanding_cnt}, 32'd0);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);

    // Both request in IDLE: data wins, inst next cycle.
    tick();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_addr = 32'h200; data_wr = 0; data_wdata = 32'hDEAD;
    mem_addr_ok = 1;
    settle();
    chk("prio_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("prio_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("prio_mem_addr", mem_addr, 32'h200);
    expect_rsp(1'b1, 32'hA1);
    tick();
    data_req = 0;
    settle();
    chk("inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("inst_mem_addr", mem_addr, 32'h100);
    chk("inst_mem_size", {30'd0, mem_size}, 32'd2);
    chk("inst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("inst_mem_wdata", mem_wdata, 32'd0);
    chk("inst_mem_wr", {31'd0, mem_wr}, 32'd0);
    expect_rsp(1'b0, 32'hA2);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'hA1;
    settle();
    chk("cnt_two", {29'd0, outstanding_cnt}, 32'd2);
    tick();
    mem_rdata = 32'hA2;
    tick();
    mem_data_ok = 0;
    settle();
    chk("cnt_drained", {29'd0, outstanding_cnt}, 32'd0);

    // Data store held for 3 cycles while inst waits; accepted on the 4th.
    tick();
    data_req = 1; data_wr = 1; data_addr = 32'h300; data_wdata = 32'hCAFE;
    data_wstrb = 4'hF; data_size = 2'd2;
    inst_req = 1; inst_addr = 32'h400; mem_addr_ok = 0;
    settle();
    chk("hold_mem_addr0", mem_addr, 32'h300);
    chk("hold_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("hold_data_addr_ok0", {31'd0, data_addr_ok}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      tick();
      settle();
      chk("hold_mem_addr", mem_addr, 32'h300);
      chk("hold_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    end
    tick();
    mem_addr_ok = 1;
    settle();
    chk("hold_accept", {31'd0, data_addr_ok}, 32'd1);
    chk("hold_wdata", mem_wdata, 32'hCAFE);
    chk("hold_wstrb", {28'd0, mem_wstrb}, 32'hF);
    expect_rsp(1'b1, 32'hB1);
    // Inst now granted but not accepted; then it withdraws.
    tick();
    data_req = 0; data_wr = 0; mem_addr_ok = 0;
    settle();
    chk("hold_i_mem_addr", mem_addr, 32'h400);
    chk("hold_i_mem_req", {31'd0, mem_req}, 32'd1);
    tick();
    inst_req = 0;
    mem_data_ok = 1; mem_rdata = 32'hB1;
    settle();
    chk("drop_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_data_ok = 0;
    settle();
    chk("store_drained", {29'd0, outstanding_cnt}, 32'd0);

    // Fill to DEPTH, verify blocking, free one slot, refill at DEPTH-1.
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      inst_req = 1; inst_addr = 32'h10 + i; mem_addr_ok = 1;
      settle();
      chk("fill_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
      expect_rsp(1'b0, 32'hC0 + i);
    end
    tick();
    inst_addr = 32'h14;
    mem_data_ok = 1; mem_rdata = 32'hC0;
    settle();
    chk("full_cnt", {29'd0, outstanding_cnt}, 32'd4);
    chk("full_mem_req", {31'd0, mem_req}, 32'd0);
    chk("full_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    mem_data_ok = 0;
    settle();
    chk("freed_cnt", {29'd0, outstanding_cnt}, 32'd3);
    chk("freed_mem_req", {31'd0, mem_req}, 32'd1);
    chk("freed_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    expect_rsp(1'b0, 32'hC4);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    settle();
    chk("refull_cnt", {29'd0, outstanding_cnt}, 32'd4);
    for (int i = 1; i <= DEPTH; i++) begin
      mem_data_ok = 1; mem_rdata = 32'hC0 + i;
      tick();
    end
    mem_data_ok = 0;
    settle();
    chk("full_drained", {29'd0, outstanding_cnt}, 32'd0);

    // inst, data, inst with in-order routing; push+pop at cnt=2.
    tick();
    inst_req = 1; inst_addr = 32'h20; mem_addr_ok = 1;
    expect_rsp(1'b0, 32'h11);
    tick();
    inst_req = 0; data_req = 1; data_addr = 32'h24;
    settle();
    chk("ord_data_ok", {31'd0, data_addr_ok}, 32'd1);
    expect_rsp(1'b1, 32'h22);
    tick();
    data_req = 0; inst_req = 1; inst_addr = 32'h28;
    mem_data_ok = 1; mem_rdata = 32'h11;
    settle();
    chk("ord_cnt_before", {29'd0, outstanding_cnt}, 32'd2);
    chk("ord_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
    expect_rsp(1'b0, 32'h33);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_rdata = 32'h22;
    settle();
    chk("ord_cnt_same", {29'd0, outstanding_cnt}, 32'd2);
    tick();
    mem_rdata = 32'h33;
    tick();
    mem_rdata = 32'h44;  // stray response with nothing in flight
    settle();
    chk("stray_cnt", {29'd0, outstanding_cnt}, 32'd0);
    chk("stray_inst_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("stray_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick();
    mem_data_ok = 0;
    settle();
    chk("stray_cnt_after", {29'd0, outstanding_cnt}, 32'd0);

    // Reset with 3 in flight and inst holding; ownership discarded.
    for (int i = 0; i < 3; i++) begin
      tick();
      inst_req = 1; inst_addr = 32'h50 + i; mem_addr_ok = 1;
    end
    tick();
    mem_addr_ok = 0;  // inst now parks in HOLD_I
    settle();
    chk("pre_rst_cnt", {29'd0, outstanding_cnt}, 32'd3);
    tick();
    reset = 1;
    settle();
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    reset = 0; data_req = 1; data_addr = 32'h600;
    mem_data_ok = 1; mem_rdata = 32'h99;
    settle();
    chk("after_rst_cnt", {29'd0, outstanding_cnt}, 32'd0);
    chk("after_rst_idle", mem_addr, 32'h600);
    chk("after_rst_inst_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("after_rst_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick();
    mem_data_ok = 0; data_req = 0; inst_req = 0;
    settle();
    chk("final_cnt", {29'd0, outstanding_cnt}, 32'd0);
    tick();
    chk("pending_rsp", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum outstanding (addr accepted, data not yet returned) transactions; a power of 2, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  instruction-fetch read request; inst_addr  input  32  word address.
REQ-005 inst_addr_ok  output  1  inst request accepted this cycle; inst_data_ok  output  1  inst read data valid; inst_rdata  output  32.
REQ-006 data_req, data_wr  input  1 each  data request, 1 = store.
REQ-007 data_size  input  2  0/1/2 = byte/half/word; data_wstrb  input  4; data_addr, data_wdata  input  32 each.
REQ-008 data_addr_ok, data_data_ok  output  1 each; data_rdata  output  32.
REQ-009 mem_req, mem_wr  output  1 each; mem_size  output  2; mem_wstrb  output  4; mem_addr, mem_wdata  output  32 each.
REQ-010 mem_addr_ok, mem_data_ok  input  1 each; mem_rdata  input  32  shared downstream SRAM-like port.
REQ-011 outstanding_cnt  output  clog2(DEPTH)+1  current number of in-flight transactions.

Function
REQ-012 Request handshake: a transaction transfers downstream in a cycle with mem_req & mem_addr_ok; response in a cycle with mem_data_ok; responses return in request order.
REQ-013 Grant FSM states: IDLE, HOLD_I, HOLD_D; reset state IDLE.
REQ-014 IDLE: if slot free, data_req wins over inst_req; grant shown combinationally the same cycle.
REQ-015 If the granted mem_req is not accepted (mem_addr_ok=0), go to HOLD_D or HOLD_I; the same requester SHALL keep the port until accepted (no switching while mem_req is high).
REQ-016 HOLD_x -> IDLE on mem_addr_ok; HOLD_x with requester req dropped -> IDLE; no port in the interim.
REQ-017 mem_* outputs SHALL mirror the granted requester; inst grant drives mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
REQ-018 mem_req=0 when no grant or outstanding_cnt==DEPTH (full); full blocks new grants even in HOLD_x.
REQ-019 x_addr_ok = mem_addr_ok & mem_req & grant==x; never asserted for the non-granted requester.
REQ-020 Owner FIFO (DEPTH entries, 1 bit: 0=inst, 1=data) SHALL push the owner on each accepted request and pop on each mem_data_ok.
REQ-021 Response routing: mem_data_ok goes to data_data_ok or inst_data_ok per FIFO head; mem_rdata forwarded to both rdata outputs unregistered (zero-latency).
REQ-022 Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
REQ-023 Same-cycle push at count==DEPTH-1 allowed; next cycle full.
REQ-024 mem_data_ok with count==0 SHALL be ignored: no x_data_ok, count stays 0.
REQ-025 Stores occupy a FIFO entry and receive data_data_ok like loads.

Reset
REQ-026 On reset: FSM IDLE; FIFO pointers and outstanding_cnt 0; all addr_ok/data_ok outputs 0 and mem_req 0 in the cycle reset is high.
REQ-027 Reset mid-operation SHALL discard all in-flight ownership; responses arriving afterwards fall under REQ-024.

Verification
REQ-028 Both inst_req and data_req high at IDLE, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0; next cycle inst granted, mem_addr = inst_addr.
REQ-029 data granted, mem_addr_ok low 3 cycles while inst_req high -> mem_addr stays data_addr, HOLD_D throughout; data_addr_ok on 4th cycle.
REQ-030 DEPTH=4, 4 inst reads accepted with no data_ok -> outstanding_cnt=4, mem_req=0 despite inst_req=1; one mem_data_ok -> cnt 3, mem_req resumes.
REQ-031 Issue inst, data, inst; return three mem_data_ok with rdata 0x11,0x22,0x33 -> inst gets 0x11, data 0x22, inst 0x33 in order.
REQ-032 Accept and mem_data_ok same cycle at cnt=2 -> cnt stays 2; mem_data_ok at cnt=0 -> no data_ok pulses.
REQ-033 Reset asserted with 3 outstanding -> cnt=0, FSM IDLE next cycle; a following mem_data_ok produces no x_data_ok.
